// File: rtl/queue_7x1_ctrl.sv
// Control logic for a 7-entry, 1-bit FIFO backed by an external ram_7x1 macro.
// Pointers wrap 6 -> 0; a maybe_full flag disambiguates full from empty.
module queue_7x1_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       io_enq_valid,
  input  logic       io_enq_bits,
  output logic       io_enq_ready,
  output logic       io_deq_valid,
  output logic       io_deq_bits,
  input  logic       io_deq_ready,
  output logic [2:0] io_count,
  output logic [2:0] R0_addr,
  output logic       R0_en,
  output logic       R0_clk,
  input  logic       R0_data,
  output logic [2:0] W0_addr,
  output logic       W0_en,
  output logic       W0_clk,
  output logic       W0_data
);

  localparam logic [2:0] LastPtr = 3'd6;

  logic [2:0] enq_ptr_q, enq_ptr_d;
  logic [2:0] deq_ptr_q, deq_ptr_d;
  logic       maybe_full_q, maybe_full_d;

  logic       ptr_match;
  logic       empty;
  logic       full;
  logic       enq_fire;
  logic       deq_fire;
  logic [2:0] ptr_diff;

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;

  // Ready/valid depend only on state, never on same-cycle handshake inputs.
  assign io_enq_ready = ~full;
  assign io_deq_valid = ~empty;

  assign enq_fire = io_enq_valid & io_enq_ready;
  assign deq_fire = io_deq_valid & io_deq_ready;

  // 3-bit difference is taken mod 8; subtracting one on wrap converts it to mod 7.
  always_comb begin
    ptr_diff = enq_ptr_q - deq_ptr_q;
    if (enq_ptr_q < deq_ptr_q) begin
      ptr_diff = ptr_diff - 3'd1;
    end
  end

  assign io_count = full ? 3'd7 : ptr_diff;

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (flush) begin
      enq_ptr_d    = 3'd0;
      deq_ptr_d    = 3'd0;
      maybe_full_d = 1'b0;
    end else begin
      if (enq_fire) begin
        enq_ptr_d = (enq_ptr_q == LastPtr) ? 3'd0 : enq_ptr_q + 3'd1;
      end
      if (deq_fire) begin
        deq_ptr_d = (deq_ptr_q == LastPtr) ? 3'd0 : deq_ptr_q + 3'd1;
      end
      if (enq_fire != deq_fire) begin
        maybe_full_d = enq_fire;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr_q    <= 3'd0;
      deq_ptr_q    <= 3'd0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Write strobe is masked while reset is held so the macro is never written then.
  assign W0_en   = enq_fire & reset;
  assign W0_addr = enq_ptr_q;
  assign W0_data = io_enq_bits;
  assign W0_clk  = clock;

  assign R0_en       = 1'b1;
  assign R0_addr     = deq_ptr_q;
  assign R0_clk      = clock;
  assign io_deq_bits = R0_data;

endmodule

// File: tb/tb_queue_7x1_ctrl.sv
// Scoreboard bench for queue_7x1_ctrl with a behavioural ram_7x1 model attached.
module tb_queue_7x1_ctrl;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       io_enq_valid;
  logic       io_enq_bits;
  logic       io_enq_ready;
  logic       io_deq_valid;
  logic       io_deq_bits;
  logic       io_deq_ready;
  logic [2:0] io_count;
  logic [2:0] R0_addr;
  logic       R0_en;
  logic       R0_clk;
  logic       R0_data;
  logic [2:0] W0_addr;
  logic       W0_en;
  logic       W0_clk;
  logic       W0_data;

  logic mem [0:6];

  int   n_total;
  int   n_pass;
  bit   sb [$];

  queue_7x1_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .io_enq_valid (io_enq_valid),
    .io_enq_bits  (io_enq_bits),
    .io_enq_ready (io_enq_ready),
    .io_deq_valid (io_deq_valid),
    .io_deq_bits  (io_deq_bits),
    .io_deq_ready (io_deq_ready),
    .io_count     (io_count),
    .R0_addr      (R0_addr),
    .R0_en        (R0_en),
    .R0_clk       (R0_clk),
    .R0_data      (R0_data),
    .W0_addr      (W0_addr),
    .W0_en        (W0_en),
    .W0_clk       (W0_clk),
    .W0_data      (W0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge W0_clk) begin
    if (W0_en) mem[W0_addr] <= W0_data;
  end
  assign R0_data = (R0_addr < 3'd7) ? mem[R0_addr] : 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every dequeue the DUT presents is checked against the scoreboard head.
  always @(negedge clock) begin
    if (reset && io_deq_valid && io_deq_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL deq_unexpected: got bit %0d expected no dequeue at %0t",
                 io_deq_bits, $time);
      end else begin
        chk("deq_bits", int'(io_deq_bits), int'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive handshake inputs, let them settle, then optionally push the written bit.
  task automatic drive(input logic ev, input logic eb, input logic dr, input bit push);
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    #1;
    if (push) sb.push_back(eb);
  endtask

  initial begin
    logic [6:0]  fill_pat;
    logic [6:0]  mix_pat;
    logic [19:0] stream_pat;
    logic [4:0]  five_pat;

    n_total = 0;
    n_pass  = 0;
    fill_pat   = 7'b1011001;
    mix_pat    = 7'b0110100;
    stream_pat = 20'b1100_1010_0111_0001_1011;
    five_pat   = 5'b10110;

    reset = 1'b0;
    flush = 1'b0;
    io_enq_valid = 1'b1;
    io_enq_bits  = 1'b1;
    io_deq_ready = 1'b0;
    #3;
    chk("rst_count", int'(io_count), 0);
    chk("rst_deq_valid", int'(io_deq_valid), 0);
    chk("rst_enq_ready", int'(io_enq_ready), 1);
    chk("rst_w0_en", int'(W0_en), 0);
    io_enq_valid = 1'b0;
    #9;
    reset = 1'b1;

    // Enqueue 1,0,1 then 1,0,0,1 to fill with pattern 1011001.
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, fill_pat[6-i], 1'b0, 1'b1);
      chk("fill_count", int'(io_count), i);
      chk("fill_w0_addr", int'(W0_addr), i);
      chk("fill_w0_en", int'(W0_en), 1);
      chk("fill_deq_valid", int'(io_deq_valid), (i == 0) ? 0 : 1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_count", int'(io_count), 7);
    chk("full_enq_ready", int'(io_enq_ready), 0);
    chk("full_w0_en", int'(W0_en), 0);

    // Full with both sides active: first cycle dequeues only.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("nopipe_enq_ready", int'(io_enq_ready), 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, mix_pat[6-i], 1'b1, 1'b1);
      chk("mix_count", int'(io_count), 6);
      chk("mix_enq_ready", int'(io_enq_ready), 1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain_count", int'(io_count), 6 - i);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drained_count", int'(io_count), 0);
    chk("drained_deq_valid", int'(io_deq_valid), 0);

    // Streaming from empty: pointers start at 0 and wrap twice over 20 bits.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, stream_pat[19-i], 1'b1, 1'b1);
      chk("stream_w0_addr", int'(W0_addr), i % 7);
      chk("stream_count", int'(io_count), (i == 0) ? 0 : 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stream_tail_count", int'(io_count), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_end_count", int'(io_count), 0);

    // Build count=4 (enq_ptr advances from 6), then flush alongside an enqueue.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, five_pat[4-i], 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("preflush_count", int'(io_count), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", int'(io_count), 0);
    chk("flush_deq_valid", int'(io_deq_valid), 0);
    chk("flush_enq_ready", int'(io_enq_ready), 1);

    // Refill to count=5; first write after flush must land at address 0.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, five_pat[4-i], 1'b0, 1'b1);
      chk("refill_w0_addr", int'(W0_addr), i);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("prereset_count", int'(io_count), 5);
    #1;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_count", int'(io_count), 0);
    chk("async_rst_deq_valid", int'(io_deq_valid), 0);
    #1;
    reset = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("postrst_w0_addr", int'(W0_addr), 0);
    chk("postrst_w0_en", int'(W0_en), 1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("postrst_count", int'(io_count), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("final_count", int'(io_count), 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule

// File: doc/queue_7x1_ctrl.md
QUEUE_7X1_CTRL -- requirements
Module: queue_7x1_ctrl

Interface
REQ-001 SHALL have no parameters; depth is fixed at 7 entries and data width at 1 bit, matching the external ram_7x1 storage macro.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately, independent of clock.
REQ-004 flush  input  1  synchronous queue clear, active-high.
REQ-005 io_enq_valid  input  1  producer has data.
REQ-006 io_enq_bits  input  1  producer data bit.
REQ-007 io_enq_ready  output  1  queue accepts a write this cycle.
REQ-008 io_deq_valid  output  1  queue holds data for the consumer.
REQ-009 io_deq_bits  output  1  head data bit.
REQ-010 io_deq_ready  input  1  consumer takes the head this cycle.
REQ-011 io_count  output  3  current occupancy, 0..7.
REQ-012 R0_addr / R0_en / R0_clk  output  3/1/1  RAM read-port drive.
REQ-013 R0_data  input  1  RAM read data; combinational from R0_addr.
REQ-014 W0_addr / W0_en / W0_clk / W0_data  output  3/1/1/1  RAM write-port drive.

Function
REQ-015 Handshakes: enq_fire = io_enq_valid & io_enq_ready; deq_fire = io_deq_valid & io_deq_ready; a transfer occurs only on fire.
REQ-016 State: enq_ptr[2:0], deq_ptr[2:0], maybe_full flag; count = 7 when enq_ptr==deq_ptr and maybe_full, otherwise (enq_ptr - deq_ptr) mod 7.
REQ-017 Pointers advance by 1 on their respective fire and wrap 6 -> 0; value 7 is never reached.
REQ-018 empty = (enq_ptr==deq_ptr) & ~maybe_full; full = (enq_ptr==deq_ptr) & maybe_full.
REQ-019 io_enq_ready = ~full; io_deq_valid = ~empty; both are independent of same-cycle valid/ready, so there is no combinational path from inputs to ready/valid.
REQ-020 No bypass: data enqueued in cycle N is visible at io_deq_bits no earlier than cycle N+1, even when the queue is empty.
REQ-021 No pipe-through: when full, io_enq_ready = 0 even if io_deq_ready = 1.
REQ-022 Simultaneous enq_fire and deq_fire: both pointers advance, maybe_full is unchanged, and count is unchanged.
REQ-023 maybe_full is set when enq_fire & ~deq_fire, and cleared when deq_fire & ~enq_fire.
REQ-024 W0_en = enq_fire; W0_addr = enq_ptr; W0_data = io_enq_bits; W0_clk = clock.
REQ-025 R0_en = 1; R0_addr = deq_ptr; R0_clk = clock; io_deq_bits = R0_data.
REQ-026 When io_deq_valid = 0, io_deq_bits is don't-care and the bench SHALL NOT check it.
REQ-027 flush = 1 at a rising edge sets enq_ptr = deq_ptr = 0 and maybe_full = 0, overriding any same-cycle fires.
REQ-028 During a flush cycle, W0_en MAY assert; the written entry is discarded logically.
REQ-029 io_count SHALL equal the REQ-016 value every cycle; io_count > 7 is illegal.

Reset
REQ-030 While reset = 0: enq_ptr = deq_ptr = 0, maybe_full = 0, io_count = 0, io_deq_valid = 0, io_enq_ready = 1, W0_en = 0.
REQ-031 Reset deassertion SHALL take effect at the next rising clock edge; RAM contents are not reset.
REQ-032 Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.

Verification
REQ-033 Reset, then enqueue 1,0,1 on consecutive cycles with deq_ready=0 -> count 1,2,3; W0_addr 0,1,2; deq_valid rises the cycle after the first enqueue.
REQ-034 Fill 7 entries (pattern 1011001) with deq_ready=0 -> count=7, enq_ready=0; an 8th enq_valid is not written (W0_en=0).
REQ-035 Starting full, hold deq_ready=1 and enq_valid=1 -> cycle 1 is dequeue only (count 6); afterwards one enqueue and one dequeue per cycle at count 6; output order is 1011001.
REQ-036 Stream 20 bits with both sides always active from empty -> pointers wrap 6->0 at least twice; output order equals input order; count stays in 0..1.
REQ-037 With count=4, assert flush together with enq_fire -> next cycle count=0, deq_valid=0, enq_ptr=deq_ptr=0.
REQ-038 With count=5, pulse reset low between clock edges -> count=0 and deq_valid=0 immediately; after release, the first enqueue writes W0_addr=0.
